pipe_perf_monitor: RTL and testbench

//  Synthesizable shadow tracker beside the 5-stage RISC-V pipeline, fed by fetch outputs and hazard-unit controls.

---
 rtl/pipe_perf_monitor_if.sv | 33 +++
 rtl/pipe_perf_monitor.sv | 97 +++++++++
 tb/tb_pipe_perf_monitor.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_perf_monitor_if.sv
// Signal bundle between the pipeline shadow monitor and its driver: fetch/hazard
// inputs, counter read port and retire record.
interface pipe_perf_monitor_if #(
   parameter int CNT_W = 32
);
   logic [31:0]      instr_f;
   logic [31:0]      pc_f;
   logic             stall_f;
   logic             stall_d;
   logic             flush_d;
   logic             flush_e;
   logic [1:0]       forward_ae;
   logic [1:0]       forward_be;
   logic             clr;
   logic [2:0]       rd_sel;
   logic [CNT_W-1:0] rd_data;
   logic             retire_valid;
   logic [31:0]      retire_pc;
   logic [31:0]      retire_instr;
   logic             limit_hit;

   modport master (
      output instr_f, pc_f, stall_f, stall_d, flush_d, flush_e,
             forward_ae, forward_be, clr, rd_sel,
      input  rd_data, retire_valid, retire_pc, retire_instr, limit_hit
   );

   modport slave (
      input  instr_f, pc_f, stall_f, stall_d, flush_d, flush_e,
             forward_ae, forward_be, clr, rd_sel,
      output rd_data, retire_valid, retire_pc, retire_instr, limit_hit
   );
endinterface

// File: rtl/pipe_perf_monitor.sv
// Shadow of the 5-stage pipeline (F->D->E->M->W) producing a retire record and
// saturating event counters with a sticky cycle-limit flag.
module pipe_perf_monitor #(
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 50
) (
   input logic               clk,
   input logic               reset,
   pipe_perf_monitor_if.slave bus
);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } stage_t;

   localparam stage_t      BUBBLE   = '0;
   localparam logic [63:0] LIMIT_M1 = 64'(MAX_CYCLES) - 64'd1;

   stage_t           d_q, e_q, m_q, w_q;
   logic [CNT_W-1:0] cnt [8];
   logic [CNT_W-1:0] rd_q;
   logic             limit_q;
   logic [7:0]       ev;
   logic             e_live;
   logic             w_live;
   logic             limit_edge;

   function automatic logic is_live(stage_t s);
      return s.valid && (s.instr != 32'h0);
   endfunction

   // D priority: flush beats stall; E takes a bubble on flush even while D holds.
   always_ff @(posedge clk) begin
      if (!reset) begin
         d_q <= BUBBLE;
         e_q <= BUBBLE;
         m_q <= BUBBLE;
         w_q <= BUBBLE;
      end else begin
         if (bus.flush_d)
            d_q <= BUBBLE;
         else if (!bus.stall_d)
            d_q <= '{valid: 1'b1, pc: bus.pc_f, instr: bus.instr_f};
         e_q <= bus.flush_e ? BUBBLE : d_q;
         m_q <= e_q;
         w_q <= m_q;
      end
   end

   always_comb begin
      e_live = is_live(e_q);
      w_live = is_live(w_q);
      ev     = '0;
      ev[0]  = 1'b1;
      ev[1]  = w_live;
      ev[2]  = bus.stall_d;
      ev[3]  = bus.stall_f;
      ev[4]  = bus.flush_d;
      ev[5]  = bus.flush_e;
      ev[6]  = (bus.forward_ae != 2'b00) && e_live;
      ev[7]  = (bus.forward_be != 2'b00) && e_live;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (!reset || bus.clr)
            cnt[i] <= '0;
         else if (ev[i] && (cnt[i] != '1))
            cnt[i] <= cnt[i] + CNT_W'(1);
      end
   end

   // Compare in a wide domain so a narrow counter can never alias MAX_CYCLES.
   assign limit_edge = (MAX_CYCLES != 0) && (64'(cnt[0]) == LIMIT_M1) && (cnt[0] != '1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_q    <= '0;
         limit_q <= 1'b0;
      end else begin
         rd_q <= cnt[bus.rd_sel];
         if (bus.clr)
            limit_q <= 1'b0;
         else if (limit_edge)
            limit_q <= 1'b1;
      end
   end

   assign bus.rd_data      = rd_q;
   assign bus.limit_hit    = limit_q;
   assign bus.retire_valid = w_live;
   assign bus.retire_pc    = w_q.pc;
   assign bus.retire_instr = w_q.instr;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Directed bench for pipe_perf_monitor: expected retires go into a scoreboard
// drained by a negedge monitor; counters and flags are checked directly.
module tb_pipe_perf_monitor;
   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   errors;
   bit   mon_en;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   pipe_perf_monitor_if #(.CNT_W(32)) bus ();
   pipe_perf_monitor_if #(.CNT_W(4))  bus4 ();

   pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(50)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave)
   );
   pipe_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0)) dut4 (
      .clk(clk), .reset(reset), .bus(bus4.slave)
   );

   assign bus4.instr_f    = bus.instr_f;
   assign bus4.pc_f       = bus.pc_f;
   assign bus4.stall_f    = bus.stall_f;
   assign bus4.stall_d    = bus.stall_d;
   assign bus4.flush_d    = bus.flush_d;
   assign bus4.flush_e    = bus.flush_e;
   assign bus4.forward_ae = bus.forward_ae;
   assign bus4.forward_be = bus.forward_be;
   assign bus4.clr        = bus.clr;
   assign bus4.rd_sel     = bus.rd_sel;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   always @(negedge clk) begin
      if (mon_en && bus.retire_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL retire_unexpected: pc=%h instr=%h cyc=%0d, expected no retire",
                     bus.retire_pc, bus.retire_instr, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.retire_pc !== e.pc || bus.retire_instr !== e.instr || cyc != e.cyc) begin
               errors++;
               $display("FAIL retire_order: got pc=%h instr=%h cyc=%0d, expected pc=%h instr=%h cyc=%0d",
                        bus.retire_pc, bus.retire_instr, cyc, e.pc, e.instr, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr, input int extra);
      exp_t e;
      e.pc    = pc;
      e.instr = instr;
      e.cyc   = cyc + 4 + extra;
      sb.push_back(e);
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                        input logic sd, input logic sf, input logic fd, input logic fe,
                        input logic [1:0] fa, input logic [1:0] fb);
      bus.pc_f       = pc;
      bus.instr_f    = instr;
      bus.stall_d    = sd;
      bus.stall_f    = sf;
      bus.flush_d    = fd;
      bus.flush_e    = fe;
      bus.forward_ae = fa;
      bus.forward_be = fb;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(32'h0, 32'h0, 0, 0, 0, 0, 2'b00, 2'b00);
   endtask

   task automatic check_cnt(input int sel, input logic [31:0] exp, input string name);
      bus.rd_sel = 3'(sel);
      idle(1);
      chk(name, 64'(bus.rd_data), 64'(exp));
   endtask

   task automatic drain_and_reset(input string name);
      idle(6);
      chk(name, 64'(sb.size()), 64'd0);
      sb.delete();
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      mon_en = 0;
      bus.clr = 1'b0;
      bus.rd_sel = 3'd0;

      // T1: reset with random inputs
      reset = 1'b0;
      for (int i = 0; i < 3; i++)
         drive($urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 2'($urandom), 2'($urandom));
      chk("rst_retire_valid", 64'(bus.retire_valid), 64'd0);
      chk("rst_retire_pc",    64'(bus.retire_pc),    64'd0);
      chk("rst_retire_instr", 64'(bus.retire_instr), 64'd0);
      chk("rst_rd_data",      64'(bus.rd_data),      64'd0);
      chk("rst_limit_hit",    64'(bus.limit_hit),    64'd0);
      reset = 1'b1;
      bus.rd_sel = 3'd0;
      idle(4);
      check_cnt(0, 32'd4, "t1_cycles_after_release");
      mon_en = 1;
      drain_and_reset("t1_drain");

      // T2: straight line
      push_exp(32'h0, 32'h00500093, 0); drive(32'h0, 32'h00500093, 0, 0, 0, 0, 2'b00, 2'b00);
      push_exp(32'h4, 32'h00300113, 0); drive(32'h4, 32'h00300113, 0, 0, 0, 0, 2'b00, 2'b00);
      push_exp(32'h8, 32'h002081B3, 0); drive(32'h8, 32'h002081B3, 0, 0, 0, 0, 2'b00, 2'b00);
      idle(6);
      check_cnt(1, 32'd3, "t2_retired");
      for (int s = 2; s < 8; s++) check_cnt(s, 32'd0, $sformatf("t2_cnt%0d", s));
      drain_and_reset("t2_drain");

      // T3: load-use stall, one bubble injected into E
      push_exp(32'h0, 32'h00002083, 0); drive(32'h0, 32'h00002083, 0, 0, 0, 0, 2'b00, 2'b00);
      push_exp(32'h4, 32'h00108133, 1); drive(32'h4, 32'h00108133, 0, 0, 0, 0, 2'b00, 2'b00);
      drive(32'h8, 32'h00000013, 1, 1, 0, 1, 2'b00, 2'b00);
      push_exp(32'h8, 32'h00000013, 0); drive(32'h8, 32'h00000013, 0, 0, 0, 0, 2'b00, 2'b00);
      idle(6);
      check_cnt(1, 32'd3, "t3_retired");
      check_cnt(2, 32'd1, "t3_stall_d");
      check_cnt(3, 32'd1, "t3_stall_f");
      check_cnt(4, 32'd0, "t3_flush_d");
      check_cnt(5, 32'd1, "t3_flush_e");
      drain_and_reset("t3_drain");

      // T4: taken branch at 0x10 to 0x40
      push_exp(32'h10, 32'h02000863, 0); drive(32'h10, 32'h02000863, 0, 0, 0, 0, 2'b00, 2'b00);
      drive(32'h14, 32'h00100293, 0, 0, 0, 0, 2'b00, 2'b00);
      drive(32'h18, 32'h00200313, 0, 0, 1, 1, 2'b00, 2'b00);
      push_exp(32'h40, 32'h00700393, 0); drive(32'h40, 32'h00700393, 0, 0, 0, 0, 2'b00, 2'b00);
      idle(6);
      check_cnt(1, 32'd2, "t4_retired");
      check_cnt(4, 32'd1, "t4_flush_d");
      check_cnt(5, 32'd1, "t4_flush_e");
      check_cnt(2, 32'd0, "t4_stall_d");
      drain_and_reset("t4_drain");

      // T5: forwarding counted only with a live E entry
      push_exp(32'h0, 32'h00100093, 0); drive(32'h0, 32'h00100093, 0, 0, 0, 0, 2'b00, 2'b00);
      push_exp(32'h4, 32'h00208133, 0); drive(32'h4, 32'h00208133, 0, 0, 0, 0, 2'b00, 2'b00);
      drive(32'h0, 32'h0, 0, 0, 0, 0, 2'b10, 2'b00);
      drive(32'h0, 32'h0, 0, 0, 0, 0, 2'b00, 2'b01);
      drive(32'h0, 32'h0, 0, 0, 0, 0, 2'b01, 2'b11);
      idle(6);
      check_cnt(6, 32'd1, "t5_fwd_a");
      check_cnt(7, 32'd1, "t5_fwd_b");
      check_cnt(1, 32'd2, "t5_retired");
      drain_and_reset("t5_drain");

      // T6: cycle limit, clear priority and narrow-counter saturation
      bus.rd_sel = 3'd0;
      idle(49);
      chk("t6_limit_before", 64'(bus.limit_hit), 64'd0);
      idle(1);
      chk("t6_limit_at_50", 64'(bus.limit_hit), 64'd1);
      chk("t6_rd_cycles_pre", 64'(bus.rd_data), 64'd49);
      chk("t6_narrow_sat", 64'(bus4.rd_data), 64'd15);
      chk("t6_narrow_limit_off", 64'(bus4.limit_hit), 64'd0);
      idle(3);
      chk("t6_limit_sticky", 64'(bus.limit_hit), 64'd1);
      bus.clr = 1'b1;
      drive(32'h0, 32'h0, 1, 0, 0, 0, 2'b00, 2'b00);
      bus.clr = 1'b0;
      chk("t6_limit_cleared", 64'(bus.limit_hit), 64'd0);
      check_cnt(0, 32'd0, "t6_cycles_cleared");
      check_cnt(2, 32'd0, "t6_clr_beats_event");
      drain_and_reset("t6_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
